msx_slot_select: RTL and testbench



---
 rtl/msx_slot_select.sv | 151 +++++++++++++++
 tb/tb_msx_slot_select.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/msx_slot_select.sv
// MSX primary/secondary slot selector: slot registers, {slot,subslot,page} layout index, wait handshake.
// Latency: layout_id valid in the second clock after the memory-request rise; register read data is combinational.
module msx_slot_select #(
    parameter int          PAGE_BITS    = 2,
    parameter logic [7:0]  PRI_PORT     = 8'hA8,
    parameter logic [15:0] EXP_ADDR     = 16'hFFFF,
    parameter bit          INV_READBACK = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [15:0]            cpu_addr,
    input  logic [7:0]             cpu_dout,
    input  logic                   cpu_rd,
    input  logic                   cpu_wr,
    input  logic                   cpu_mreq,
    input  logic                   cpu_iorq,
    input  logic                   cpu_m1,
    input  logic [3:0]             exp_en,
    input  logic [3:0]             exp_mask,
    output logic [7:0]             cpu_din,
    output logic                   dout_en,
    output logic                   cpu_wait,
    output logic [PAGE_BITS+3:0]   layout_id,
    output logic                   layout_valid,
    output logic [1:0]             active_slot,
    output logic                   exp_hit
);
    localparam int PAGES = 1 << PAGE_BITS;
    localparam int RW    = 2 * PAGES;
    localparam int NB    = RW / 8;
    localparam int LW    = PAGE_BITS + 4;

    typedef enum logic [1:0] {IDLE, LOOKUP, ACTIVE} state_t;

    state_t           state_q;
    logic [RW-1:0]    pri_q;
    logic [RW-1:0]    sec_q [4];
    logic             mreq_q;
    logic [LW-1:0]    lat_q;
    logic [LW-1:0]    layout_id_q;
    logic             layout_valid_q;

    logic [PAGE_BITS-1:0] page;
    logic [1:0]       cur_slot;
    logic [1:0]       cur_sub;
    logic [1:0]       top_slot;
    logic [3:0]       slot_exp;
    logic             pri_match, sec_match;
    logic [0:0]       pri_idx, sec_idx;
    logic [7:0]       pri_byte, sec_byte;
    logic             pri_acc, hit, start;

    assign page     = cpu_addr[15 -: PAGE_BITS];
    // A masked slot behaves exactly like a non-expanded one.
    assign slot_exp = exp_en & exp_mask;
    assign cur_slot = pri_q[{page, 1'b0} +: 2];
    assign cur_sub  = slot_exp[cur_slot] ? sec_q[cur_slot][{page, 1'b0} +: 2] : 2'b00;
    assign top_slot = pri_q[RW-1 -: 2];

    always_comb begin
        pri_match = 1'b0;
        pri_idx   = '0;
        sec_match = 1'b0;
        sec_idx   = '0;
        pri_byte  = 8'h00;
        sec_byte  = 8'h00;
        for (int k = 0; k < NB; k++) begin
            if (cpu_addr[7:0] == PRI_PORT + 8'(k)) begin
                pri_match = 1'b1;
                pri_idx   = 1'(k);
                pri_byte  = pri_q[8*k +: 8];
            end
            if (cpu_addr == EXP_ADDR - 16'(k)) begin
                sec_match = 1'b1;
                sec_idx   = 1'(k);
                sec_byte  = sec_q[top_slot][8*k +: 8];
            end
        end
    end

    // Primary access takes priority if the bus ever shows both strobes.
    assign pri_acc = cpu_iorq & ~cpu_m1 & pri_match;
    assign hit     = cpu_mreq & sec_match & slot_exp[top_slot] & ~pri_acc;
    assign start   = (state_q == IDLE) & cpu_mreq & ~mreq_q & (cpu_rd | cpu_wr);

    always_comb begin
        cpu_din = 8'hFF;
        dout_en = 1'b0;
        if (reset_n && pri_acc && cpu_rd) begin
            cpu_din = pri_byte;
            dout_en = 1'b1;
        end else if (reset_n && hit && cpu_rd) begin
            cpu_din = INV_READBACK ? ~sec_byte : sec_byte;
            dout_en = 1'b1;
        end
    end

    assign exp_hit      = reset_n & hit;
    assign cpu_wait     = reset_n & (start | (state_q == LOOKUP));
    assign layout_id    = layout_id_q;
    assign layout_valid = layout_valid_q & ~exp_hit;
    assign active_slot  = cur_slot;

    always_ff @(posedge clk) begin
        mreq_q <= cpu_mreq;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pri_q <= '0;
            for (int i = 0; i < 4; i++) sec_q[i] <= '0;
        end else if (pri_acc && cpu_wr) begin
            for (int k = 0; k < NB; k++)
                if (pri_idx == 1'(k)) pri_q[8*k +: 8] <= cpu_dout;
        end else if (hit && cpu_wr) begin
            for (int k = 0; k < NB; k++)
                if (sec_idx == 1'(k)) sec_q[top_slot][8*k +: 8] <= cpu_dout;
        end
    end

    // Selection is captured at cycle start, so a subslot write lands on the next access.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            lat_q          <= '0;
            layout_id_q    <= '0;
            layout_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        lat_q   <= {cur_slot, cur_sub, page};
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    layout_id_q    <= lat_q;
                    layout_valid_q <= 1'b1;
                    state_q        <= ACTIVE;
                end
                ACTIVE: begin
                    if (!cpu_mreq) begin
                        layout_valid_q <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msx_slot_select.sv
// Bench for msx_slot_select: 4-page and 8-page instances share one bus, checked against a rule-level model.
module tb_msx_slot_select;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rd, cpu_wr, cpu_mreq, cpu_iorq, cpu_m1;
    logic [3:0]  exp_en, exp_mask;

    logic [7:0]  din2, din3;
    logic        den2, den3, wait2, wait3, lv2, lv3, eh2, eh3;
    logic [5:0]  id2;
    logic [6:0]  id3;
    logic [1:0]  as2, as3;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_pri [2];
    logic [15:0] m_sec [2][4];

    always #5 clk = ~clk;

    msx_slot_select #(.PAGE_BITS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_mreq(cpu_mreq), .cpu_iorq(cpu_iorq),
        .cpu_m1(cpu_m1), .exp_en(exp_en), .exp_mask(exp_mask), .cpu_din(din2),
        .dout_en(den2), .cpu_wait(wait2), .layout_id(id2), .layout_valid(lv2),
        .active_slot(as2), .exp_hit(eh2));

    msx_slot_select #(.PAGE_BITS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_mreq(cpu_mreq), .cpu_iorq(cpu_iorq),
        .cpu_m1(cpu_m1), .exp_en(exp_en), .exp_mask(exp_mask), .cpu_din(din3),
        .dout_en(den3), .cpu_wait(wait3), .layout_id(id3), .layout_valid(lv3),
        .active_slot(as3), .exp_hit(eh3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int pb_of(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int m_slot(int i, logic [15:0] a);
        int pg = int'(a >> (16 - pb_of(i)));
        return int'((m_pri[i] >> (2 * pg)) & 16'd3);
    endfunction

    function automatic int m_layout(int i, logic [15:0] a);
        int pb  = pb_of(i);
        int pg  = int'(a >> (16 - pb));
        int sl  = m_slot(i, a);
        int sub = (exp_en[sl] && exp_mask[sl]) ? int'((m_sec[i][sl] >> (2 * pg)) & 16'd3) : 0;
        return (sl << (pb + 2)) | (sub << pb) | pg;
    endfunction

    function automatic int m_top(int i);
        return int'((m_pri[i] >> (2 * ((1 << pb_of(i)) - 1))) & 16'd3);
    endfunction

    function automatic bit m_hit(int i, logic [15:0] a);
        int ts = m_top(i);
        bit match = (a == 16'hFFFF) || (pb_of(i) == 3 && a == 16'hFFFE);
        return match && exp_en[ts] && exp_mask[ts];
    endfunction

    task automatic bus_idle();
        cpu_mreq = 1'b0; cpu_iorq = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_m1 = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pri[i] = '0;
            for (int s = 0; s < 4; s++) m_sec[i][s] = '0;
        end
    endtask

    task automatic io(input logic [7:0] port, input bit wr, input logic [7:0] d, input bit m1);
        int k;
        @(negedge clk);
        cpu_addr = {8'($urandom_range(0, 255)), port};
        cpu_dout = d; cpu_iorq = 1'b1; cpu_wr = wr; cpu_rd = !wr; cpu_m1 = m1;
        #2;
        k = int'(port) - 8'hA8;
        for (int i = 0; i < 2; i++) begin
            bit sel = !m1 && (k == 0 || (k == 1 && pb_of(i) == 3));
            logic [7:0] exp_d = (sel && !wr) ? m_pri[i][8*k +: 8] : 8'hFF;
            chk($sformatf("io_din%0d_%h", i, port), (i == 0) ? din2 : din3, exp_d);
            chk($sformatf("io_den%0d_%h", i, port), (i == 0) ? den2 : den3, sel && !wr);
            if (sel && wr) m_pri[i][8*k +: 8] = d;
        end
        @(negedge clk);
        bus_idle();
    endtask

    task automatic mem(input logic [15:0] a, input bit wr, input logic [7:0] d);
        int eid [2];
        bit eh [2];
        @(negedge clk);
        cpu_addr = a; cpu_dout = d; cpu_mreq = 1'b1; cpu_wr = wr; cpu_rd = !wr;
        #2;
        for (int i = 0; i < 2; i++) begin
            int k = (a == 16'hFFFF) ? 0 : 1;
            int ts = m_top(i);
            logic [7:0] exp_d;
            eh[i]  = m_hit(i, a);
            eid[i] = m_layout(i, a);
            exp_d  = (eh[i] && !wr) ? ~m_sec[i][ts][8*k +: 8] : 8'hFF;
            chk($sformatf("m_wait0_%0d", i), (i == 0) ? wait2 : wait3, 1);
            chk($sformatf("m_hit%0d_%h", i, a), (i == 0) ? eh2 : eh3, eh[i]);
            chk($sformatf("m_din%0d_%h", i, a), (i == 0) ? din2 : din3, exp_d);
            chk($sformatf("m_den%0d_%h", i, a), (i == 0) ? den2 : den3, eh[i] && !wr);
            chk($sformatf("m_aslot%0d_%h", i, a), (i == 0) ? as2 : as3, m_slot(i, a));
            if (eh[i] && wr) m_sec[i][ts][8*k +: 8] = d;
        end
        @(negedge clk); #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("m_wait1_%0d", i), (i == 0) ? wait2 : wait3, 1);
            chk($sformatf("m_lv_lookup%0d", i), (i == 0) ? lv2 : lv3, 0);
        end
        @(negedge clk); #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("m_wait2_%0d", i), (i == 0) ? wait2 : wait3, 0);
            chk($sformatf("m_id%0d_%h", i, a), (i == 0) ? 32'(id2) : 32'(id3), eid[i]);
            chk($sformatf("m_lv%0d_%h", i, a), (i == 0) ? lv2 : lv3, !eh[i]);
        end
        @(negedge clk);
        bus_idle();
    endtask

    initial begin
        bus_idle();
        cpu_addr = '0; cpu_dout = '0; exp_en = '0; exp_mask = 4'hF;
        model_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_wait", {wait2, wait3}, 0);
        chk("rst_den", {den2, den3}, 0);
        chk("rst_din", {din2, din3}, 16'hFFFF);
        chk("rst_lv", {lv2, lv3}, 0);
        chk("rst_id", {id2, id3}, 0);
        chk("rst_eh", {eh2, eh3}, 0);
        chk("rst_as", {as2, as3}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        io(8'hA8, 0, 8'h00, 0);
        mem(16'h4000, 0, 8'h00);
        chk("tp1_id", id2, 6'b00_00_01);

        exp_en = 4'b1000;
        io(8'hA8, 1, 8'hF0, 0);
        mem(16'hFFFF, 1, 8'h40);
        mem(16'hC000, 0, 8'h00);
        chk("tp2_id", id2, 6'b11_01_11);
        mem(16'hFFFF, 0, 8'h00);

        exp_mask = 4'b0111;
        mem(16'hFFFF, 0, 8'h00);
        chk("tp3_id", id2, 6'b11_00_11);
        exp_mask = 4'b1111;

        io(8'hA9, 1, 8'hC0, 0);
        mem(16'hE000, 0, 8'h00);
        chk("tp4_id3", id3, 7'b11_00_111);

        io(8'hA8, 1, 8'h40, 0);
        mem(16'hFFFF, 1, 8'h5A);
        exp_en = 4'b1010;
        mem(16'hFFFF, 0, 8'h00);

        io(8'hA8, 1, 8'h3C, 1);
        io(8'hA8, 0, 8'h00, 0);

        for (int n = 0; n < 250; n++) begin
            int op = $urandom_range(0, 5);
            logic [15:0] a;
            case ($urandom_range(0, 2))
                0: a = 16'hFFFF;
                1: a = 16'hFFFE;
                default: a = 16'($urandom);
            endcase
            case (op)
                0: io($urandom_range(0, 1) ? 8'hA9 : 8'hA8, 1, 8'($urandom), 0);
                1: io($urandom_range(0, 1) ? 8'hA9 : 8'hA8, 0, 8'h00, 0);
                2: mem(a, 1, 8'($urandom));
                3: mem(a, 0, 8'h00);
                4: begin exp_en = 4'($urandom); exp_mask = 4'($urandom); end
                default: mem(16'($urandom), 0, 8'h00);
            endcase
        end

        @(negedge clk);
        cpu_addr = 16'h4000; cpu_mreq = 1'b1; cpu_rd = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk); #2;
        chk("rstmid_wait", {wait2, wait3}, 0);
        chk("rstmid_lv", {lv2, lv3}, 0);
        chk("rstmid_id", {id2, id3}, 0);
        bus_idle();
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        io(8'hA8, 0, 8'h00, 0);
        io(8'hA9, 0, 8'h00, 0);
        mem(16'hC000, 0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
